// File: rtl/car_pkg.sv
// Shared types and constants for the car simulator front-end blocks.
package car_pkg;

  // Power-button FSM states.
  typedef enum logic [2:0] {
    ST_OFF          = 3'd0,
    ST_ARMING       = 3'd1,
    ST_ON_WAIT_REL  = 3'd2,
    ST_ON           = 3'd3,
    ST_OFF_WAIT_REL = 3'd4
  } pwr_state_e;

  // Drive-mode encodings seen by the top level.
  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_MANUAL = 2'b01;
  localparam logic [1:0] MODE_SEMI   = 2'b10;
  localparam logic [1:0] MODE_AUTO   = 2'b11;

  // Default timing at 100 MHz: 20 ms debounce, 1 s long press.
  localparam int DEF_DEBOUNCE_CYCLES   = 2_000_000;
  localparam int DEF_LONG_PRESS_CYCLES = 100_000_000;

  // Decode switches {auto, semi, manual}: bit 2 = exactly one set, [1:0] = mode.
  function automatic logic [2:0] decode_switches(input logic [2:0] sw);
    logic [2:0] res;
    case (sw)
      3'b001:  res = {1'b1, MODE_MANUAL};
      3'b010:  res = {1'b1, MODE_SEMI};
      3'b100:  res = {1'b1, MODE_AUTO};
      default: res = {1'b0, MODE_OFF};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability-counter debouncer.
module btn_debounce
  import car_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from btn_db long enough.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      btn_db <= 1'b0;
    end else if (sync2 != btn_db) begin
      if (cnt == CNT_MAX) begin
        btn_db <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/power_mode_ctrl.sv
// Power button long-press FSM, force-off handling and drive-mode register.
module power_mode_ctrl
  import car_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_btn,
  input  logic       manul_mode,
  input  logic       semi_auto_mode,
  input  logic       auto_mode,
  input  logic       force_off,
  output logic       power_state,
  output logic [1:0] mode,
  output logic       power_on_pulse,
  output pwr_state_e dbg_state
);

  localparam int HW = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES - 1);

  logic          btn_db;
  logic          db_prev;
  logic [2:0]    sw_s1;
  logic [2:0]    sw_s2;
  logic [2:0]    sw_dec;
  pwr_state_e    state;
  pwr_state_e    state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;
  logic          pulse_nxt;
  logic          powered_nxt;
  logic [1:0]    mode_nxt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(power_btn),
    .btn_db (btn_db)
  );

  assign dbg_state = state;
  assign sw_dec    = decode_switches(sw_s2);

  // Synchronize the mode switches (levels only, no debounce) and keep the
  // previous debounced button level for edge detection in ON.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1   <= 3'b000;
      sw_s2   <= 3'b000;
      db_prev <= 1'b0;
    end else begin
      sw_s1   <= {auto_mode, semi_auto_mode, manul_mode};
      sw_s2   <= sw_s1;
      db_prev <= btn_db;
    end
  end

  // Next state, hold counter and registered-output values.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    pulse_nxt = 1'b0;
    case (state)
      ST_OFF: begin
        if (btn_db && !force_off) begin
          state_nxt = ST_ARMING;
          hold_nxt  = '0;
        end
      end
      ST_ARMING: begin
        if (force_off) begin
          state_nxt = ST_OFF_WAIT_REL;
        end else if (!btn_db) begin
          state_nxt = ST_OFF;
        end else if (hold_cnt == HOLD_MAX) begin
          state_nxt = ST_ON_WAIT_REL;
          pulse_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      ST_ON_WAIT_REL: begin
        if (force_off) begin
          state_nxt = ST_OFF_WAIT_REL;
        end else if (!btn_db) begin
          state_nxt = ST_ON;
        end
      end
      ST_ON: begin
        if (force_off || (btn_db && !db_prev)) begin
          state_nxt = ST_OFF_WAIT_REL;
        end
      end
      ST_OFF_WAIT_REL: begin
        if (!force_off && !btn_db) begin
          state_nxt = ST_OFF;
        end
      end
      default: state_nxt = ST_OFF;
    endcase

    powered_nxt = (state_nxt == ST_ON_WAIT_REL) || (state_nxt == ST_ON);

    mode_nxt = mode;
    if (!powered_nxt) begin
      mode_nxt = MODE_OFF;
    end else if (pulse_nxt) begin
      mode_nxt = sw_dec[2] ? sw_dec[1:0] : MODE_MANUAL;
    end else if (sw_dec[2]) begin
      mode_nxt = sw_dec[1:0];
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_OFF;
      hold_cnt       <= '0;
      power_state    <= 1'b0;
      mode           <= MODE_OFF;
      power_on_pulse <= 1'b0;
    end else begin
      state          <= state_nxt;
      hold_cnt       <= hold_nxt;
      power_state    <= powered_nxt;
      mode           <= mode_nxt;
      power_on_pulse <= pulse_nxt;
    end
  end

endmodule

// File: doc/power_mode_ctrl.md
# power_mode_ctrl

Power and drive-mode front end for the car simulator top level. It debounces the power button and applies the long-press power-on rule. It arbitrates the three mode switches and a forced-off request. It drives the power state and the 2-bit drive mode that the top level uses to enable the manual, semi-auto and auto controllers.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 2_000_000: cycles a synchronized level must stay stable before it is accepted (20 ms at 100 MHz).
- `LONG_PRESS_CYCLES`, default 100_000_000: debounced hold time required for power-on (1 s at 100 MHz).

Ports:
- `clk`, in, 1: 100 MHz system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `power_btn`, in, 1: raw power push-button, active-high, asynchronous to `clk`.
- `manul_mode`, in, 1: manual mode switch.
- `semi_auto_mode`, in, 1: semi-auto mode switch.
- `auto_mode`, in, 1: auto mode switch.
- `force_off`, in, 1: synchronous power-off request from downstream (e.g. engine stall). Level-sensitive.
- `power_state`, out, 1: 1 = powered on, 0 = off.
- `mode`, out, 2: 00 = off, 01 = manual, 10 = semi-auto, 11 = auto.
- `power_on_pulse`, out, 1: one-cycle strobe on every off→on transition.

## Operation
- **Synchronizer.** `power_btn` passes through 2 flip-flops. Mode switches also pass through 2 flip-flops each. They are not debounced.
- **Debouncer.**
  - Counter compares the synchronized level against `btn_db`.
  - On mismatch the counter increments. When it reaches `DEBOUNCE_CYCLES-1`, `btn_db` takes the new level and the counter clears.
  - Any match clears the counter.
- **FSM** (states in package enum):
  - **OFF:** `btn_db`=1 → ARMING, hold counter cleared.
  - **ARMING:** hold counter increments while `btn_db`=1.
    - `btn_db`=0 before the count reaches `LONG_PRESS_CYCLES-1` → OFF. A short press does nothing.
    - Count reaches `LONG_PRESS_CYCLES-1` → ON_WAIT_REL, `power_on_pulse`=1 for that cycle.
  - **ON_WAIT_REL:** powered. Waits for `btn_db`=0, then → ON. The held power-on press must not also power off.
  - **ON:** `btn_db` rising (0→1) → OFF_WAIT_REL.
  - **OFF_WAIT_REL:** unpowered. `btn_db`=0 → OFF.
  - **`force_off`** in ON_WAIT_REL or ON → OFF_WAIT_REL next cycle. It has priority over button events. In OFF, ARMING or OFF_WAIT_REL it holds or returns the FSM to OFF/OFF_WAIT_REL: ARMING aborts to OFF_WAIT_REL.
- **Power state.** `power_state`=1 exactly in ON_WAIT_REL and ON.
- **Mode register:**
  - Unpowered states force `mode`=00.
  - On entry to ON_WAIT_REL, `mode` loads from the switches if exactly one is set. Otherwise it loads 01.
  - While powered, the register updates every cycle in which exactly one synchronized switch is set: manul→01, semi→10, auto→11.
  - Zero or multiple switches set → `mode` holds its value.

## Timing
- **Reset values:** FSM=OFF, `power_state`=0, `mode`=00, `power_on_pulse`=0, `btn_db`=0, all counters 0.
- **Power-on latency:** from the raw press edge, 2 (sync) + `DEBOUNCE_CYCLES` + `LONG_PRESS_CYCLES` cycles (±1) until `power_state` rises.
- **Power-off latency:**
  - Button: 2 + `DEBOUNCE_CYCLES` cycles.
  - `force_off`: `power_state`=0 the cycle after `force_off` is sampled high.
- **Registered outputs:** all outputs are registered. `power_state` and `mode` change in the same cycle. `power_on_pulse` coincides with the first cycle of `power_state`=1.
- **Mode-switch latency:** 3 cycles from a switch change to `mode` (2 sync + 1 register).
- **Counter widths:** `$clog2` of the respective parameter. Counters saturate and never wrap.
- **Reset mid-operation:** immediate return to reset values, with no pulse emitted.

## Structure
- **Shared package `car_pkg`:**
  - FSM state enum (OFF, ARMING, ON_WAIT_REL, ON, OFF_WAIT_REL).
  - Mode encodings MODE_OFF/MANUAL/SEMI/AUTO.
  - Default cycle constants.
- **Sub-module `btn_debounce`:** sync + debounce, parameter `DEBOUNCE_CYCLES`, ports `clk`, `rst`, `btn_raw`, `btn_db`. It is reused for other panel buttons.
- **Remainder** (FSM, hold counter, mode register) lives in `power_mode_ctrl`.

## Test plan
Use `DEBOUNCE_CYCLES`=4 and `LONG_PRESS_CYCLES`=16.
- **Long press:** reset, hold `power_btn` 30 cycles with `manul_mode`=1 → `power_state` 0→1 about 22 cycles after the press, `mode`=01, `power_on_pulse` high exactly 1 cycle. Release → stays on.
- **Short press and glitch:** `power_btn` high 10 cycles then low → `power_state` stays 0, no pulse. A 2-cycle glitch → `btn_db` never rises.
- **Power off by button:** while ON, press 6 cycles → `power_state`=0 and `mode`=00 about 6 cycles after the press. Keep holding 40 cycles → no re-power until release and a fresh long press.
- **Mode arbitration:** while ON, `auto_mode`=1 alone → `mode`=11 after 3 cycles. Set `semi_auto_mode` as well → `mode` holds 11. Clear `auto_mode` → `mode`=10.
- **`force_off`:** while ON, pulse `force_off` 1 cycle → next cycle `power_state`=0, `mode`=00. Assert it during ARMING → no power-on.
- **Async reset:** drop `rst` while ON mid-cycle → outputs 0/00 immediately. Release → OFF, and a short press does not power on.
